clk_rst_gen: RTL and testbench

Synthesizable testbench clock/reset source. It derives a 50%-duty divided clock (clk_tb) from the reference clock. It also produces an active-low reset (rst_n) that stays asserted for a programmable number of clk_tb periods. It sits at the top of the verification harness and feeds the clock and reset to the sequencer and the DUT.

---
 rtl/clk_rst_gen_pkg.sv | 18 +
 rtl/clk_rst_gen_if.sv | 26 ++
 rtl/clk_div_toggle.sv | 48 ++++
 rtl/clk_rst_gen.sv | 79 +++++++
 tb/tb_clk_rst_gen.sv | 117 +++++++++++
 5 files changed

// File: rtl/clk_rst_gen_pkg.sv
// Shared types and constants for the clock/reset generator.
package clk_rst_gen_pkg;

   typedef enum logic [1:0] {
      S_RESET,
      S_HOLD,
      S_RUN
   } t_rst_state;

   localparam int C_CLK_HALF_PERIOD = 5;
   localparam int C_WAIT_RST        = 16;

   // Bits needed to hold the values 0..n.
   function automatic int f_cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/clk_rst_gen_if.sv
// Generated clock/reset bundle handed to the sequencer and the DUT.
interface clk_rst_gen_if;

   logic clk_tb;
   logic rst_n;
   logic clk_tb_rise;
   logic clk_tb_fall;
   logic rst_done;

   modport master (
      output clk_tb,
      output rst_n,
      output clk_tb_rise,
      output clk_tb_fall,
      output rst_done
   );

   modport slave (
      input clk_tb,
      input rst_n,
      input clk_tb_rise,
      input clk_tb_fall,
      input rst_done
   );

endinterface

// File: rtl/clk_div_toggle.sv
// Half-period counter and toggle flop producing a 50%-duty divided clock
// with registered rise/fall strobes.
module clk_div_toggle
   import clk_rst_gen_pkg::*;
#(
   parameter int G_HALF = C_CLK_HALF_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic clk_tb,
   output logic rise,
   output logic fall,
   output logic fall_evt
);

   localparam int              CW     = f_cnt_width(G_HALF);
   localparam logic [CW-1:0]   C_LAST = CW'(G_HALF - 1);

   logic [CW-1:0] cnt;
   logic          tc;

   assign tc       = en && (cnt == C_LAST);
   // High in the cycle whose edge will drop clk_tb, so the parent can act on
   // that same edge.
   assign fall_evt = tc && clk_tb;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         clk_tb <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (tc) begin
            cnt    <= '0;
            clk_tb <= ~clk_tb;
            rise   <= ~clk_tb;
            fall   <= clk_tb;
         end else if (en) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/clk_rst_gen.sv
// Divided clock plus an active-low reset released on a clk_tb falling edge
// after a programmable number of clk_tb periods.
module clk_rst_gen
   import clk_rst_gen_pkg::*;
#(
   parameter int G_CLK_HALF_PERIOD = C_CLK_HALF_PERIOD,
   parameter int G_WAIT_RST        = C_WAIT_RST
) (
   input  logic            clk,
   input  logic            rst,
   clk_rst_gen_if.master   bus
);

   if (G_CLK_HALF_PERIOD < 1) begin : g_bad_half
      $error("clk_rst_gen: G_CLK_HALF_PERIOD must be >= 1");
   end
   if (G_WAIT_RST < 1) begin : g_bad_wait
      $error("clk_rst_gen: G_WAIT_RST must be >= 1");
   end

   localparam int            PW     = f_cnt_width(G_WAIT_RST);
   localparam logic [PW-1:0] C_WAIT = PW'(G_WAIT_RST);

   t_rst_state    state;
   logic [PW-1:0] period_cnt;
   logic [PW-1:0] period_nxt;
   logic          rst_n_q;
   logic          run;
   logic          fall_evt;
   logic          clk_tb;
   logic          rise;
   logic          fall;

   // The divider stays frozen during the first post-reset edge (S_RESET).
   assign run        = (state != S_RESET);
   assign period_nxt = (period_cnt == C_WAIT) ? period_cnt : period_cnt + 1'b1;

   clk_div_toggle #(
      .G_HALF   (G_CLK_HALF_PERIOD)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .en       (run),
      .clk_tb   (clk_tb),
      .rise     (rise),
      .fall     (fall),
      .fall_evt (fall_evt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_RESET;
         period_cnt <= '0;
         rst_n_q    <= 1'b0;
      end else begin
         case (state)
            S_RESET: state <= S_HOLD;
            S_HOLD: begin
               if (fall_evt) begin
                  period_cnt <= period_nxt;
                  if (period_nxt == C_WAIT) begin
                     rst_n_q <= 1'b1;
                     state   <= S_RUN;
                  end
               end
            end
            S_RUN: rst_n_q <= 1'b1;
            default: state <= S_RESET;
         endcase
      end
   end

   assign bus.clk_tb      = clk_tb;
   assign bus.clk_tb_rise = rise;
   assign bus.clk_tb_fall = fall;
   assign bus.rst_n       = rst_n_q;
   assign bus.rst_done    = rst_n_q;

endmodule

// File: tb/tb_clk_rst_gen.sv
// Bench for clk_rst_gen: three configurations driven by one reset pattern,
// each compared every cycle against a closed-form timing model.
module tb_clk_rst_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   clk_rst_gen_if if_a ();
   clk_rst_gen_if if_b ();
   clk_rst_gen_if if_c ();

   clk_rst_gen #(.G_CLK_HALF_PERIOD(5), .G_WAIT_RST(16)) u_a (.clk(clk), .rst(rst), .bus(if_a));
   clk_rst_gen #(.G_CLK_HALF_PERIOD(1), .G_WAIT_RST(1))  u_b (.clk(clk), .rst(rst), .bus(if_b));
   clk_rst_gen #(.G_CLK_HALF_PERIOD(3), .G_WAIT_RST(4))  u_c (.clk(clk), .rst(rst), .bus(if_c));

   int n_checks = 0;
   int n_fail   = 0;
   int t        = -1;
   int n_rise   = 0;
   int n_fall   = 0;
   int run_len  = 0;
   logic seen_tgl = 1'b0;
   logic prev_c   = 1'b0;
   logic rst_s;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s t=%0d got=%0h expected=%0h", tag, t, obs, exp);
      end
   endtask

   // Expected {clk_tb, rise, fall, rst_n, rst_done} after edge t (t<0: in reset).
   function automatic logic [4:0] model(input int tt, input int h, input int w);
      logic [4:0] v;
      v = '0;
      if (tt >= 0) begin
         v[4] = ((tt / h) % 2) == 1;
         v[3] = (tt >= h) && ((tt % (2 * h)) == h);
         v[2] = (tt > 0) && ((tt % (2 * h)) == 0);
         v[1] = tt >= 2 * w * h;
         v[0] = v[1];
      end
      return v;
   endfunction

   // Observer: sample 1 time unit after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         rst_s = rst;
         #1;
         if (rst_s) t = -1;
         else       t = t + 1;
         check_eq("h5w16", 32'({if_a.clk_tb, if_a.clk_tb_rise, if_a.clk_tb_fall, if_a.rst_n, if_a.rst_done}),
                  32'(model(t, 5, 16)));
         check_eq("h1w1", 32'({if_b.clk_tb, if_b.clk_tb_rise, if_b.clk_tb_fall, if_b.rst_n, if_b.rst_done}),
                  32'(model(t, 1, 1)));
         check_eq("h3w4", 32'({if_c.clk_tb, if_c.clk_tb_rise, if_c.clk_tb_fall, if_c.rst_n, if_c.rst_done}),
                  32'(model(t, 3, 4)));
         if (rst_s) begin
            seen_tgl = 1'b0;
            run_len  = 0;
            n_rise   = 0;
            n_fall   = 0;
         end else begin
            if (if_c.clk_tb_rise) n_rise++;
            if (if_c.clk_tb_fall) n_fall++;
            if (if_c.clk_tb !== prev_c) begin
               if (seen_tgl) check_eq("h3_phase_len", 32'(run_len), 32'd3);
               seen_tgl = 1'b1;
               run_len  = 1;
            end else begin
               run_len++;
            end
         end
         prev_c = if_c.clk_tb;
      end
   end

   // Edges t=0..n-1 see rst=0; the edge at t=n sees whatever follows.
   task automatic run_for(input int n);
      rst = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic hold_rst(input int n);
      rst = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      run_for(7);          // reset lands at t=7 while h5w16 clk_tb is high
      hold_rst(2);
      run_for(300);        // reset in S_RUN at t=300
      hold_rst(1);
      run_for(170);        // release at t=160 again
      hold_rst(3);
      for (int i = 0; i < 15; i++) begin
         run_for(int'($urandom_range(1, 400)));
         hold_rst(int'($urandom_range(1, 4)));
      end
      run_for(600);        // 100 periods of the H=3 clock
      check_eq("h3_rise_cnt", 32'(n_rise), 32'd100);
      check_eq("h3_fall_cnt", 32'(n_fall), 32'd99);
      check_eq("h3_rise_fall_bal", 32'((n_rise - n_fall <= 1) && (n_fall - n_rise <= 1)), 32'd1);
      hold_rst(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
